alu_seq: RTL and testbench

Parametrised, registered successor to the processor's combinational ALU. Keeps the same 5-bit op encoding (0..18) and adds a Start/Ready/Valid handshake. DIV and MOD run on an iterative restoring divider, so they take multiple cycles. Sits in the execute stage; the control unit stalls while In_Ready=0.

---
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with Start/In_Ready/Out_Valid handshake; DIV/MOD use an iterative restoring divider.
// Optional feature macro: ALU_SIGNED_EN (adds the Signed input for two's-complement compare/shift/divide).
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       ALU_Op,
    input  logic [WIDTH-1:0] Data_1,
    input  logic [WIDTH-1:0] Data_2,
`ifdef ALU_SIGNED_EN
    input  logic             Signed,
`endif
    output logic             In_Ready,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] Result,
    output logic             True,
    output logic             Div_Zero,
    output logic [1:0]       Dbg_State
);

    // Handshake: a request is taken on a rising edge where Start=1 and In_Ready=1;
    // Out_Valid is a one-cycle pulse and Result/True/Div_Zero hold until the next pulse.

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4,  OP_AND = 5'd5,  OP_OR  = 5'd6,  OP_XOR = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8,  OP_SHL = 5'd9,  OP_SHR = 5'd10, OP_EQ  = 5'd11;
    localparam logic [4:0] OP_NE  = 5'd12, OP_GE  = 5'd13, OP_GT  = 5'd14, OP_LE  = 5'd15;
    localparam logic [4:0] OP_LT  = 5'd16, OP_NOP = 5'd17, OP_IMM = 5'd18;

    localparam logic [WIDTH-1:0]   WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   quo_q, rem_q, dvs_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               is_mod_q, qneg_q, rneg_q;

    logic               sgn_c;
    logic [WIDTH-1:0]   res_c, mag_a_c, mag_b_c;
    logic               true_c, dz_c, div_op_c, big_sh_c, eq_c, lt_c, cmp_op_c;
    logic [SHAMT_W-1:0] sh_c;
    logic [WIDTH:0]     shift_d;
    logic               fits_d;

`ifdef ALU_SIGNED_EN
    assign sgn_c = Signed;
`else
    assign sgn_c = 1'b0;
`endif

    assign Dbg_State = state_q;

    always_comb begin
        sh_c     = Data_2[SHAMT_W-1:0];
        big_sh_c = Data_2 >= WIDTH_V;
        eq_c     = Data_1 == Data_2;
        lt_c     = sgn_c ? ($signed(Data_1) < $signed(Data_2)) : (Data_1 < Data_2);
        div_op_c = (ALU_Op == OP_DIV) || (ALU_Op == OP_MOD);
        dz_c     = div_op_c && (Data_2 == '0);
        cmp_op_c = (ALU_Op >= OP_EQ) && (ALU_Op <= OP_LT);
        mag_a_c  = (sgn_c && Data_1[WIDTH-1]) ? -Data_1 : Data_1;
        mag_b_c  = (sgn_c && Data_2[WIDTH-1]) ? -Data_2 : Data_2;
        res_c    = '0;
        true_c   = 1'b0;
        case (ALU_Op)
            OP_ADD: res_c = Data_1 + Data_2;
            OP_SUB: res_c = Data_1 - Data_2;
            OP_MUL: res_c = Data_1 * Data_2;
            // DIV/MOD only take this path when the divisor is zero
            OP_DIV: res_c = '1;
            OP_MOD: res_c = Data_1;
            OP_AND: res_c = Data_1 & Data_2;
            OP_OR:  res_c = Data_1 | Data_2;
            OP_XOR: res_c = Data_1 ^ Data_2;
            OP_NOT: res_c = ~Data_1;
            OP_SHL: res_c = big_sh_c ? '0 : (Data_1 << sh_c);
            OP_SHR: begin
                if (sgn_c)
                    res_c = big_sh_c ? {WIDTH{Data_1[WIDTH-1]}} : WIDTH'($signed(Data_1) >>> sh_c);
                else
                    res_c = big_sh_c ? '0 : (Data_1 >> sh_c);
            end
            OP_EQ:  true_c = eq_c;
            OP_NE:  true_c = !eq_c;
            OP_GE:  true_c = !lt_c;
            OP_GT:  true_c = !lt_c && !eq_c;
            OP_LE:  true_c = lt_c || eq_c;
            OP_LT:  true_c = lt_c;
            OP_NOP: res_c = '0;
            OP_IMM: res_c = Data_2;
            default: res_c = '0;
        endcase
        if (cmp_op_c)
            res_c = {{(WIDTH-1){1'b0}}, true_c};
        // One restoring step: bring in the next dividend bit and try to subtract the divisor
        shift_d = {rem_q, quo_q[WIDTH-1]};
        fits_d  = shift_d >= {1'b0, dvs_q};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            Result    <= '0;
            True      <= 1'b0;
            Div_Zero  <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            is_mod_q  <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            Out_Valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        if (div_op_c && !dz_c) begin
                            quo_q    <= mag_a_c;
                            rem_q    <= '0;
                            dvs_q    <= mag_b_c;
                            cnt_q    <= '0;
                            is_mod_q <= ALU_Op == OP_MOD;
                            qneg_q   <= sgn_c && (Data_1[WIDTH-1] ^ Data_2[WIDTH-1]);
                            rneg_q   <= sgn_c && Data_1[WIDTH-1];
                            In_Ready <= 1'b0;
                            state_q  <= S_DIV;
                        end else begin
                            Result    <= res_c;
                            True      <= true_c;
                            Div_Zero  <= dz_c;
                            Out_Valid <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= fits_d ? shift_d[WIDTH-1:0] - dvs_q : shift_d[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], fits_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    // Signs are restored here: quotient truncates toward zero, remainder follows the dividend
                    if (is_mod_q)
                        Result <= rneg_q ? -rem_q : rem_q;
                    else
                        Result <= qneg_q ? -quo_q : quo_q;
                    True      <= 1'b0;
                    Div_Zero  <= 1'b0;
                    Out_Valid <= 1'b1;
                    In_Ready  <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    In_Ready <= 1'b1;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); signed cases run when ALU_SIGNED_EN is defined.
module tb_alu_seq;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [4:0]  ALU_Op = '0;
    logic [31:0] Data_1 = '0;
    logic [31:0] Data_2 = '0;
`ifdef ALU_SIGNED_EN
    logic        sgn = 1'b0;
`endif
    logic        In_Ready, Out_Valid, True, Div_Zero;
    logic [31:0] Result;
    logic [1:0]  Dbg_State;

    int n_chk = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .ALU_Op(ALU_Op),
        .Data_1(Data_1), .Data_2(Data_2),
`ifdef ALU_SIGNED_EN
        .Signed(sgn),
`endif
        .In_Ready(In_Ready), .Out_Valid(Out_Valid), .Result(Result),
        .True(True), .Div_Zero(Div_Zero), .Dbg_State(Dbg_State)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request for a single edge; returns 1ns after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clock);
        Start = 1'b1; ALU_Op = op; Data_1 = a; Data_2 = b;
        @(posedge Clock);
        #1;
        Start = 1'b0;
    endtask

    task automatic run1(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic t);
        string tag;
        tag = $sformatf("op%0d_%h_%h", op, a, b);
        issue(op, a, b);
        chk({tag, "_valid"}, Out_Valid, 1);
        chk({tag, "_result"}, Result, r);
        chk({tag, "_true"}, True, t);
        chk({tag, "_dz"}, Div_Zero, 0);
        chk({tag, "_ready"}, In_Ready, 1);
    endtask

    // Multi-cycle divide; optionally holds a stray Start with changing operands during the busy window.
    task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input int hold);
        string tag;
        int    cyc;
        logic  ir_ok;
        tag   = $sformatf("div%0d_%h_%h", op, a, b);
        ir_ok = 1'b1;
        cyc   = 0;
        issue(op, a, b);
        for (int i = 1; i <= 100; i++) begin
            @(negedge Clock);
            if (i <= hold) begin
                Start = 1'b1; ALU_Op = 5'd0; Data_1 = 32'h1111 * i; Data_2 = 32'd3;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clock);
            #1;
            if (Out_Valid) begin
                cyc = i;
                break;
            end
            if (In_Ready) ir_ok = 1'b0;
        end
        Start = 1'b0;
        chk({tag, "_busy"}, ir_ok, 1);
        chk({tag, "_latency"}, cyc, 33);
        chk({tag, "_result"}, Result, r);
        chk({tag, "_true"}, True, 0);
        chk({tag, "_dz"}, Div_Zero, 0);
        chk({tag, "_ready"}, In_Ready, 1);
        @(posedge Clock);
        #1;
        chk({tag, "_pulse"}, Out_Valid, 0);
    endtask

    task automatic run_dz(input logic [4:0] op, input logic [31:0] a, input logic [31:0] r);
        string tag;
        tag = $sformatf("dz%0d_%h", op, a);
        issue(op, a, 32'd0);
        chk({tag, "_valid"}, Out_Valid, 1);
        chk({tag, "_result"}, Result, r);
        chk({tag, "_dz"}, Div_Zero, 1);
        chk({tag, "_true"}, True, 0);
        chk({tag, "_ready"}, In_Ready, 1);
    endtask

    initial begin
        int ov_cnt;

        repeat (2) @(posedge Clock);
        #1;
        chk("rst_ready", In_Ready, 1);
        chk("rst_valid", Out_Valid, 0);
        chk("rst_result", Result, 0);
        chk("rst_true", True, 0);
        chk("rst_dz", Div_Zero, 0);
        @(negedge Clock);
        Reset = 1'b0;

        run1(5'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 0);

        // Back-to-back single-cycle ops on consecutive edges
        run1(5'd16, 32'd3, 32'd5, 32'd1, 1);
        run1(5'd9, 32'd1, 32'd40, 32'd0, 0);
        @(posedge Clock);
        #1;
        chk("b2b_idle_valid", Out_Valid, 0);

        run1(5'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 0);
        run1(5'd2,  32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 0);
        run1(5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
        run1(5'd6,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 0);
        run1(5'd7,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 0);
        run1(5'd8,  32'h1234_5678, 32'd0,         32'hEDCB_A987, 0);
        run1(5'd9,  32'd1,         32'd31,        32'h8000_0000, 0);
        run1(5'd9,  32'd1,         32'd32,        32'd0,         0);
        run1(5'd10, 32'h8000_0000, 32'd4,         32'h0800_0000, 0);
        run1(5'd10, 32'hFFFF_FFFF, 32'd33,        32'd0,         0);
        run1(5'd11, 32'd9,         32'd9,         32'd1,         1);
        run1(5'd12, 32'd9,         32'd9,         32'd0,         0);
        run1(5'd13, 32'd5,         32'd5,         32'd1,         1);
        run1(5'd14, 32'd5,         32'd5,         32'd0,         0);
        run1(5'd14, 32'hFFFF_FFFF, 32'd1,         32'd1,         1);
        run1(5'd15, 32'd6,         32'd5,         32'd0,         0);
        run1(5'd17, 32'd7,         32'd8,         32'd0,         0);
        run1(5'd18, 32'd7,         32'h0000_ABCD, 32'h0000_ABCD, 0);
        run1(5'd20, 32'd5,         32'd5,         32'd0,         0);

        run_div(5'd3, 32'd100,       32'd7,   32'd14,        20);
        run_div(5'd4, 32'd100,       32'd7,   32'd2,         0);
        run_div(5'd3, 32'hFFFF_FFFF, 32'h10,  32'h0FFF_FFFF, 0);
        run_div(5'd4, 32'hFFFF_FFFF, 32'h10,  32'h0000_000F, 0);
        run_div(5'd3, 32'd7,         32'd100, 32'd0,         0);
        run_div(5'd4, 32'd7,         32'd100, 32'd7,         0);

        run_dz(5'd3, 32'd5, 32'hFFFF_FFFF);
        run_dz(5'd4, 32'd5, 32'd5);

        // Reset ten iterations into a divide: nothing may come out afterwards
        issue(5'd3, 32'd1000, 32'd3);
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("abort_ready", In_Ready, 1);
        chk("abort_valid", Out_Valid, 0);
        chk("abort_result", Result, 0);
        chk("abort_dz", Div_Zero, 0);
        @(negedge Clock);
        Reset = 1'b0;
        ov_cnt = 0;
        repeat (40) begin
            @(posedge Clock);
            #1;
            if (Out_Valid) ov_cnt++;
        end
        chk("abort_no_valid", ov_cnt, 0);
        run1(5'd0, 32'd40, 32'd2, 32'd42, 0);

`ifdef ALU_SIGNED_EN
        sgn = 1'b1;
        run1(5'd14, 32'hFFFF_FFFF, 32'd1,  32'd0,         0);
        run1(5'd16, 32'hFFFF_FFFF, 32'd1,  32'd1,         1);
        run1(5'd10, 32'h8000_0000, 32'd4,  32'hF800_0000, 0);
        run1(5'd10, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 0);
        run_div(5'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        run_div(5'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        run_div(5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_div(5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
        sgn = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
